// File: rtl/pwl_delay_ctrl.sv
// pwl_delay_ctrl: slews a PWL delay code one LSB per settle interval toward a handshaked target
module pwl_delay_ctrl #(
    parameter int  N        = 6,
    parameter real T_MIN    = 10e-12,
    parameter real T_LSB    = 1e-12,
    parameter int  SETTLE   = 4,
    parameter int  RST_CODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] target_code,
    input  logic         target_valid,
    output logic         target_ready,
    input  logic         en,
    output logic [N-1:0] code,
    output real          delay,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, STEP, WAIT} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] tgt;
    logic [7:0]   cnt;
    logic         last_tick;

    // final settle cycle of the current step; the step after this edge is decided here
    assign last_tick = en && cnt <= 8'd1;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic; en freezes STEP and WAIT but never IDLE acceptance
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (target_valid && target_code != code) ? STEP : IDLE;
            STEP:    state_nxt = en ? WAIT : STEP;
            WAIT:    state_nxt = last_tick ? ((code == tgt) ? IDLE : STEP) : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: target latch, one-LSB code step, settle counter, registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            code <= RST_CODE[N-1:0];
            tgt  <= RST_CODE[N-1:0];
            cnt  <= 8'd0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && target_valid) begin
                tgt  <= target_code;
                done <= target_code == code;
            end
            if (state == STEP && en) begin
                code <= (tgt > code) ? code + 1'b1 : code - 1'b1;
                cnt  <= SETTLE[7:0];
            end
            if (state == WAIT && en) begin
                cnt  <= cnt - 8'd1;
                done <= last_tick && code == tgt;
            end
        end
    end

    // outputs decoded from registers only; delay tracks the registered code with no skew
    always_comb begin
        target_ready = state == IDLE;
        busy         = state != IDLE;
        delay        = T_MIN + real'(code) * T_LSB;
    end
endmodule
